// File: rtl/dmem_pkg.sv
// Shared size codes, FSM state type and size helper for the data-memory arbiter.
package dmem_pkg;

  localparam logic [1:0] SZ_WORD   = 2'b00;
  localparam logic [1:0] SZ_BYTE_U = 2'b01;
  localparam logic [1:0] SZ_BYTE_S = 2'b10;
  localparam logic [1:0] SZ_RSVD   = 2'b11;

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_e;

  // The reserved code is treated as a full 16-bit access.
  function automatic logic [1:0] legal_size(input logic [1:0] sz);
    return (sz == SZ_RSVD) ? SZ_WORD : sz;
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin arbiter; the pointer remembers the last winner.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  // 1 = port 1 won last, so port 0 is favoured next
  logic last_q, last_d;

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last_q ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

  always_comb begin
    last_d = last_q;
    if (advance) last_d = gnt[1];
  end

  always_ff @(posedge clk) begin
    if (reset) last_q <= 1'b1;
    else       last_q <= last_d;
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-ported data memory between the MEM stage (port 0) and the
// loader (port 1); every access runs IDLE -> ISSUE -> RESP.
//   state | meaning
//   IDLE  | waiting for a request, grant and latch the winner
//   ISSUE | memory enables driven from the latched request
//   RESP  | done strobe to the owner, read data steered back
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int AW = 16,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic [1:0]    size0,
  input  logic [1:0]    size1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          done0,
  output logic          done1,
  output logic [DW-1:0] rdata0,
  output logic [DW-1:0] rdata1,
  output logic          busy,
  output logic          mem_wr_en,
  output logic          mem_rd_en,
  output logic [1:0]    mem_size,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  state_e        state_q, state_d;
  logic          owner_q, owner_d;
  logic          we_q, we_d;
  logic          mem_wr_en_q, mem_wr_en_d;
  logic          mem_rd_en_q, mem_rd_en_d;
  logic [1:0]    mem_size_q, mem_size_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;

  logic [1:0]    arb_gnt;
  logic          accept;
  logic          sel_we;
  logic [1:0]    sel_size;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;
  logic          resp_live;

  assign accept = (state_q == IDLE) && !reset && (req0 || req1);
  assign gnt0   = accept && arb_gnt[0];
  assign gnt1   = accept && arb_gnt[1];

  rr_arbiter2 u_rr (
    .clk     (clk),
    .reset   (reset),
    .req     ({req1, req0}),
    .advance (accept),
    .gnt     (arb_gnt)
  );

  assign sel_we    = arb_gnt[1] ? we1    : we0;
  assign sel_size  = arb_gnt[1] ? size1  : size0;
  assign sel_addr  = arb_gnt[1] ? addr1  : addr0;
  assign sel_wdata = arb_gnt[1] ? wdata1 : wdata0;

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    we_d        = we_q;
    mem_wr_en_d = 1'b0;
    mem_rd_en_d = 1'b0;
    mem_size_d  = mem_size_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d     = ISSUE;
          owner_d     = arb_gnt[1];
          we_d        = sel_we;
          mem_wr_en_d = sel_we;
          mem_rd_en_d = !sel_we;
          // Writes always store a full word, so size only matters for reads
          mem_size_d  = sel_we ? SZ_WORD : legal_size(sel_size);
          mem_addr_d  = sel_addr;
          mem_wdata_d = sel_wdata;
        end
      end
      ISSUE:   state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      owner_q     <= 1'b0;
      we_q        <= 1'b0;
      mem_wr_en_q <= 1'b0;
      mem_rd_en_q <= 1'b0;
      mem_size_q  <= SZ_WORD;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      we_q        <= we_d;
      mem_wr_en_q <= mem_wr_en_d;
      mem_rd_en_q <= mem_rd_en_d;
      mem_size_q  <= mem_size_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  // Reset during RESP suppresses the strobe so an aborted access never completes
  assign resp_live = (state_q == RESP) && !reset;
  assign done0     = resp_live && !owner_q;
  assign done1     = resp_live && owner_q;
  assign rdata0    = (done0 && !we_q) ? mem_rdata : '0;
  assign rdata1    = (done1 && !we_q) ? mem_rdata : '0;
  assign busy      = (state_q != IDLE);

  assign mem_wr_en = mem_wr_en_q;
  assign mem_rd_en = mem_rd_en_q;
  assign mem_size  = mem_size_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: byte-array memory behind the pins and a transaction
// level reference (accept cycle + phase offset, round-robin by last winner).
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0, req1, we0, we1;
  logic [1:0]  size0, size1;
  logic [15:0] addr0, addr1, wdata0, wdata1;
  logic        gnt0, gnt1, done0, done1, busy;
  logic [15:0] rdata0, rdata1;
  logic        mem_wr_en, mem_rd_en;
  logic [1:0]  mem_size;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  dmem_arbiter #(.AW(16), .DW(16)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .size0(size0), .size1(size1), .addr0(addr0), .addr1(addr1),
    .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .rdata0(rdata0), .rdata1(rdata1), .busy(busy),
    .mem_wr_en(mem_wr_en), .mem_rd_en(mem_rd_en), .mem_size(mem_size),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Pin-level memory: big-endian word, address wraps, registered read port
  bit [7:0]    dev_mem [0:65535];
  logic [15:0] dev_a1;
  assign dev_a1 = mem_addr + 16'd1;
  always @(posedge clk) begin
    if (mem_wr_en) begin
      dev_mem[mem_addr] <= mem_wdata[15:8];
      dev_mem[dev_a1]   <= mem_wdata[7:0];
    end
    if (mem_rd_en) begin
      case (mem_size)
        2'b01:   mem_rdata <= {8'h00, dev_mem[mem_addr]};
        2'b10:   mem_rdata <= {{8{dev_mem[mem_addr][7]}}, dev_mem[mem_addr]};
        default: mem_rdata <= {dev_mem[mem_addr], dev_mem[dev_a1]};
      endcase
    end
  end

  // Reference state
  bit [7:0]    exp_mem [0:65535];
  int          cyc = 0;
  bit          live = 0;
  int          acc = 0;
  int          last_port = 1;
  int          t_owner;
  bit          t_we;
  logic [1:0]  t_size;
  logic [15:0] t_addr, t_wdata, t_rdata;

  int          nchecks = 0;
  int          nerr = 0;
  bit [1:0]    gnt_prev, done_prev;
  logic [15:0] last_rd [2];
  logic [1:0]  last_issue_size;
  int          grant_log[$];
  int          done_log[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchecks++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [15:0] ref_read(input logic [15:0] a, input logic [1:0] sz);
    logic [15:0] a1;
    a1 = a + 16'd1;
    case (sz)
      2'b01:   return {8'h00, exp_mem[a]};
      2'b10:   return {{8{exp_mem[a][7]}}, exp_mem[a]};
      default: return {exp_mem[a], exp_mem[a1]};
    endcase
  endfunction

  // One clock: sample at the falling edge, compare, advance the reference
  task automatic step();
    int ph, w;
    bit inflight;
    logic [1:0] eg, ed;
    logic [15:0] er0, er1, a1;
    @(negedge clk);
    ph = live ? cyc - acc : 0;
    inflight = live && (ph == 1 || ph == 2);
    eg = 2'b00; w = 0;
    if (!reset && !inflight && (req0 || req1)) begin
      if (req0 && req1) w = 1 - last_port;
      else              w = req1 ? 1 : 0;
      eg[w] = 1'b1;
    end
    ed = 2'b00; er0 = '0; er1 = '0;
    if (live && ph == 2 && !reset) begin
      ed[t_owner] = 1'b1;
      if (!t_we) begin
        if (t_owner == 1) er1 = t_rdata;
        else              er0 = t_rdata;
      end
    end
    check("gnt", {gnt1, gnt0}, eg);
    check("done", {done1, done0}, ed);
    check("rdata0", rdata0, er0);
    check("rdata1", rdata1, er1);
    check("busy", busy, inflight);
    check("wr_en", mem_wr_en, live && ph == 1 && t_we);
    check("rd_en", mem_rd_en, live && ph == 1 && !t_we);
    if (live && ph == 1) begin
      check("mem_addr", mem_addr, t_addr);
      check("mem_size", mem_size, t_size);
      if (t_we) check("mem_wdata", mem_wdata, t_wdata);
    end
    if (gnt0 || gnt1) grant_log.push_back(gnt1 ? 1 : 0);
    if (done0 || done1) done_log.push_back(done1 ? 1 : 0);
    if (done0) last_rd[0] = rdata0;
    if (done1) last_rd[1] = rdata1;
    if (mem_rd_en || mem_wr_en) last_issue_size = mem_size;
    gnt_prev  = {gnt1, gnt0};
    done_prev = {done1, done0};

    if (reset) begin
      live = 0;
      last_port = 1;
    end else if (eg != 2'b00) begin
      live    = 1;
      acc     = cyc;
      t_owner = w;
      t_we    = (w == 1) ? we1 : we0;
      t_addr  = (w == 1) ? addr1 : addr0;
      t_wdata = (w == 1) ? wdata1 : wdata0;
      t_size  = (w == 1) ? size1 : size0;
      if (t_size == 2'b11) t_size = 2'b00;
      if (t_we) begin
        t_size = 2'b00;
        a1 = t_addr + 16'd1;
        exp_mem[t_addr] = t_wdata[15:8];
        exp_mem[a1]     = t_wdata[7:0];
      end else begin
        t_rdata = ref_read(t_addr, t_size);
      end
      last_port = w;
    end else if (live && ph == 2) begin
      live = 0;
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic set_port(input int p, input logic r, input logic we,
                          input logic [1:0] sz, input logic [15:0] a, input logic [15:0] wd);
    if (p == 0) begin req0 = r; we0 = we; size0 = sz; addr0 = a; wdata0 = wd; end
    else        begin req1 = r; we1 = we; size1 = sz; addr1 = a; wdata1 = wd; end
  endtask

  task automatic txn(input int p, input logic we, input logic [1:0] sz,
                     input logic [15:0] a, input logic [15:0] wd);
    int n;
    set_port(p, 1'b1, we, sz, a, wd);
    n = 0;
    do begin step(); n++; end while (!gnt_prev[p] && n < 10);
    check("gnt_seen", gnt_prev[p], 1'b1);
    if (p == 0) req0 = 1'b0; else req1 = 1'b0;
    n = 0;
    do begin step(); n++; end while (!done_prev[p] && n < 10);
    check("done_seen", done_prev[p], 1'b1);
  endtask

  initial begin
    reset = 1'b1;
    set_port(0, 1'b0, 1'b0, 2'b00, 16'h0, 16'h0);
    set_port(1, 1'b0, 1'b0, 2'b00, 16'h0, 16'h0);
    @(posedge clk); #1;
    step(); step();
    check("rst_addr", mem_addr, 16'h0000);
    check("rst_size", mem_size, 2'b00);
    check("rst_wdata", mem_wdata, 16'h0000);
    reset = 1'b0;

    grant_log.delete(); done_log.delete();
    repeat (10) step();
    check("idle_gnts", grant_log.size(), 0);
    check("idle_dones", done_log.size(), 0);

    txn(0, 1'b1, 2'b00, 16'h0002, 16'h0303);
    txn(0, 1'b0, 2'b00, 16'h0002, 16'h0000);
    check("rd_word", last_rd[0], 16'h0303);
    txn(0, 1'b1, 2'b00, 16'h0010, 16'h8500);
    txn(0, 1'b0, 2'b01, 16'h0010, 16'h0000);
    check("rd_byte_u", last_rd[0], 16'h0085);
    txn(0, 1'b0, 2'b10, 16'h0010, 16'h0000);
    check("rd_byte_s", last_rd[0], 16'hFF85);
    txn(0, 1'b0, 2'b11, 16'h0010, 16'h0000);
    check("rsvd_size", last_issue_size, 2'b00);
    check("rsvd_data", last_rd[0], 16'h8500);
    txn(1, 1'b1, 2'b01, 16'h0020, 16'hBEEF);
    txn(1, 1'b0, 2'b00, 16'h0020, 16'h0000);
    check("wr_rd_p1", last_rd[1], 16'hBEEF);
    txn(1, 1'b1, 2'b00, 16'hFFFF, 16'h1234);
    txn(1, 1'b0, 2'b00, 16'h0000, 16'h0000);
    check("wrap_word", last_rd[1], 16'h3400);

    // Contention from reset
    reset = 1'b1;
    set_port(0, 1'b1, 1'b0, 2'b00, 16'h0002, 16'h0);
    set_port(1, 1'b1, 1'b0, 2'b00, 16'h0020, 16'h0);
    step();
    reset = 1'b0;
    grant_log.delete(); done_log.delete();
    repeat (12) step();
    req0 = 1'b0; req1 = 1'b0;
    repeat (3) step();
    check("cont_ngnt", grant_log.size(), 4);
    check("cont_ndone", done_log.size(), 4);
    for (int i = 0; i < 4 && i < grant_log.size() && i < done_log.size(); i++) begin
      check("cont_gnt_order", grant_log[i], i % 2);
      check("cont_done_owner", done_log[i], i % 2);
    end

    // Reset during ISSUE of a read: abort, then port 0 preferred again
    txn(1, 1'b1, 2'b00, 16'h0004, 16'h1111);
    set_port(0, 1'b1, 1'b0, 2'b00, 16'h0020, 16'h0);
    step();
    check("abort_gnt", gnt_prev, 2'b01);
    req0 = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
    check("abort_done", done_prev, 2'b00);
    check("abort_addr", mem_addr, 16'h0000);
    check("abort_busy", busy, 1'b0);
    set_port(0, 1'b1, 1'b0, 2'b00, 16'h0002, 16'h0);
    set_port(1, 1'b1, 1'b0, 2'b00, 16'h0004, 16'h0);
    step();
    check("post_rst_pref", gnt_prev, 2'b01);
    req0 = 1'b0; req1 = 1'b0;
    repeat (3) step();

    // Randomized traffic with occasional resets
    for (int c = 0; c < 2000; c++) begin
      reset = ($urandom_range(79) == 0);
      for (int p = 0; p < 2; p++) begin
        logic r;
        r = (p == 0) ? req0 : req1;
        if (r && gnt_prev[p]) begin
          if (p == 0) req0 = 1'b0; else req1 = 1'b0;
        end else if (!r && $urandom_range(2) == 0) begin
          set_port(p, 1'b1, 1'($urandom_range(1)), 2'($urandom_range(3)),
                   ($urandom_range(7) == 0) ? 16'hFFFF : 16'($urandom_range(31)),
                   16'($urandom));
        end
      end
      step();
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchecks);
    $finish;
  end

endmodule
